inst_decode_queue: RTL
======================

// Module: inst_decode_queue
// PURPOSE
//  Downstream neighbour of the RAM fetch port. Captures each {pc, inst} returned by RAM
//  into a DEPTH-entry FIFO and presents the head entry, RV32I-decoded, to the execute
//  stage over a valid/ready handshake. in_ready is the back-pressure signal to the IFU.
//  flush discards all queued instructions (redirect).
// PARAMETERS
//  DEPTH   4   FIFO entries; power of 2, >= 2
//  XLEN    32  pc/inst/imm width; fixed at 32
// PORTS
//  clk          in   1      clock, all state on posedge
//  rst          in   1      synchronous reset, ACTIVE-LOW (rst==0 resets)
//  flush        in   1      synchronous queue clear
//  in_valid     in   1      RAM returned an instruction this cycle (driven by RAM ready)
//  in_pc        in   32     pc of the instruction
//  in_inst      in   32     instruction word
//  in_ready     out  1      queue can accept (not full)
//  out_valid    out  1      head entry valid
//  out_ready    in   1      consumer takes head this cycle
//  out_pc       out  32     head pc
//  out_inst     out  32     head raw instruction
//  out_opcode   out  7      inst[6:0]
//  out_rd       out  5      inst[11:7]
//  out_rs1      out  5      inst[19:15]
//  out_rs2      out  5      inst[24:20]
//  out_funct3   out  3      inst[14:12]
//  out_funct7   out  7      inst[31:25]
//  out_imm      out  32     sign-extended immediate per format
//  out_illegal  out  1      opcode not RV32I base, or inst[1:0]!=2'b11
//  count        out  clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Reset (rst==0): rd/wr pointers and count cleared; out_valid=0, count=0, in_ready=0
//    during reset, 1 from the first cycle after reset release. Entry storage not reset.
//  - Pointers are clog2(DEPTH)+1 bits; the extra bit distinguishes full from empty on wrap.
//  - push = in_valid & in_ready; pop = out_valid & out_ready. in_valid while !in_ready
//    is dropped (IFU must hold pc); no assertion in RTL.
//  - in_ready = (count != DEPTH). Full blocks push even if pop occurs that cycle (no
//    full-pass-through). Empty: no bypass; push-to-out_valid latency 1 cycle.
//  - Simultaneous push and pop when 0<count<DEPTH: count unchanged, both pointers advance.
//  - flush: next cycle count=0, out_valid=0; dominates push/pop in the same cycle.
//    rst dominates flush.
//  - Decode is combinational from the head entry. When out_valid=0 every out_* data
//    output (pc, inst, fields, imm, illegal) is driven 0.
//  - imm: I (0000011,0010011,1100111,1110011) {{20{i[31]}},i[31:20]};
//    S (0100011) {{20{i[31]}},i[31:25],i[11:7]}; B (1100011) {{19{i[31]}},i[31],i[7],
//    i[30:25],i[11:8],1'b0}; U (0110111,0010111) {i[31:12],12'b0}; J (1101111)
//    {{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}; R/fence/illegal: 0.
//  - Legal opcodes: 0110111,0010111,1101111,1100111,1100011,0000011,0100011,
//    0010011,0110011,0001111,1110011. Illegal entries still flow; only flagged.
// CONFIGURATION
//  INST_QUEUE_PERF_EN defined: extra outputs perf_pop_cnt[31:0] (increments per pop)
//    and perf_full_cyc[31:0] (increments each cycle count==DEPTH and rst==1);
//    both cleared by rst, NOT by flush, wrap modulo 2^32.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1 rst=0 3 cycles -> out_valid=0, count=0, in_ready=0; rst=1 -> in_ready=1 next cycle.
//  2 push pc=0x80000000 inst=0x00500093, out_ready=1 -> next cycle out_valid=1,
//    opcode=0x13 rd=1 rs1=0 imm=0x00000005 illegal=0; popped, following cycle out_valid=0.
//  3 push 0xFE000EE3 then 0x123452B7 -> imm 0xFFFFFFFC (B) then 0x12345000 (U), rd=5.
//  4 DEPTH=4, out_ready=0, 5 back-to-back pushes -> in_ready=0 after 4th, count=4,
//    5th dropped; then pop 4 -> pcs in push order, count=0, in_ready=1.
//  5 count=2, push+pop same cycle -> count stays 2; then flush with in_valid=1 ->
//    count=0, out_valid=0 next cycle, pushed entry discarded.
//  6 push inst=0x00000000 -> out_illegal=1, imm=0; with PERF_EN perf_pop_cnt counts it.

Source files
------------

// File: rtl/inst_decode_queue.sv
// Instruction queue between the RAM fetch port and execute: DEPTH-entry FIFO of {pc, inst}
// with a combinational RV32I decode of the head. Optional perf counters: INST_QUEUE_PERF_EN.
module inst_decode_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_inst,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_inst,
  output logic [6:0]                 out_opcode,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [2:0]                 out_funct3,
  output logic [6:0]                 out_funct7,
  output logic [XLEN-1:0]            out_imm,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     count
`ifdef INST_QUEUE_PERF_EN
  ,
  output logic [31:0]                perf_pop_cnt,
  output logic [31:0]                perf_full_cyc
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            rdy_q;
  logic            push, pop, full;
  logic [XLEN-1:0] head;
  logic            legal_op;

  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == CW'(DEPTH));
  // rdy_q keeps in_ready low until the first cycle after reset release
  assign in_ready  = rdy_q & ~full;
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rdy_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr[AW-1:0]]   <= in_pc;
      inst_mem[wr_ptr[AW-1:0]] <= in_inst;
    end
  end

  // Zeroing the head word zeroes every decoded field when the queue is empty
  assign head       = out_valid ? inst_mem[rd_ptr[AW-1:0]] : '0;
  assign out_pc     = out_valid ? pc_mem[rd_ptr[AW-1:0]] : '0;
  assign out_inst   = head;
  assign out_opcode = head[6:0];
  assign out_rd     = head[11:7];
  assign out_funct3 = head[14:12];
  assign out_rs1    = head[19:15];
  assign out_rs2    = head[24:20];
  assign out_funct7 = head[31:25];

  always_comb begin
    out_imm  = '0;
    legal_op = 1'b1;
    case (head[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
        out_imm = {{20{head[31]}}, head[31:20]};
      7'b0100011:
        out_imm = {{20{head[31]}}, head[31:25], head[11:7]};
      7'b1100011:
        out_imm = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        out_imm = {head[31:12], 12'b0};
      7'b1101111:
        out_imm = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
      7'b0110011, 7'b0001111:
        out_imm = '0;
      default:
        legal_op = 1'b0;
    endcase
  end

  assign out_illegal = out_valid & (~legal_op | (head[1:0] != 2'b11));

`ifdef INST_QUEUE_PERF_EN
  // Flush deliberately leaves these running; only reset clears them
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_pop_cnt  <= '0;
      perf_full_cyc <= '0;
    end else begin
      if (pop)  perf_pop_cnt  <= perf_pop_cnt + 32'd1;
      if (full) perf_full_cyc <= perf_full_cyc + 32'd1;
    end
  end
`endif

endmodule
